// File: rtl/sw_event_arbiter_pkg.sv
// Shared types and helpers for the switch event arbiter: controller states,
// ARM length and the round-robin selection function.
package sw_arb_pkg;

  localparam int ARM_CYCLES = 3;
  localparam int MAX_N      = 8;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_OFFER,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... (mod n) and return the first set pending bit.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] pend,
                                    input logic [2:0]       ptr,
                                    input int               n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = 0; k < MAX_N; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !r.found && pend[j]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_event_arbiter_if.sv
// Event handshake between the arbiter (master) and the switch-driven FSM (slave).
interface sw_event_arbiter_if #(
  parameter int N = 4
);

  localparam int IW = $clog2(N);

  logic          evt_valid;
  logic          evt_ready;
  logic [N-1:0]  evt_onehot;
  logic [IW-1:0] evt_idx;

  modport master (
    output evt_valid,
    output evt_onehot,
    output evt_idx,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_onehot,
    input  evt_idx,
    output evt_ready
  );

endinterface

// File: rtl/sw_event_arbiter_sync_edge.sv
// Per-bit 2-FF synchroniser, optional debounce (SW_DEBOUNCE_EN), prev register
// and a registered rise pulse that is suppressed while mask is high.
module sw_sync_edge #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_in,
  input  logic         mask,
  output logic [N-1:0] rise,
  output logic         settled
);

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] level;
  logic [N-1:0] prev;
  logic [N-1:0] rise_q;

  // Edge detect runs on the filtered level; masking happens before the
  // register so a level already high at reset release never becomes a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      rise_q <= '0;
    end else begin
      sync1  <= sw_in;
      sync2  <= sync1;
      prev   <= level;
      rise_q <= level & ~prev & {N{~mask}};
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [N];
  logic [N-1:0]  deb;

  // The debounced level follows sync2 only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level   = deb;
  assign settled = (sync1 == deb) && (sync2 == deb) && (prev == deb);
`else
  assign level   = sync2;
  assign settled = 1'b1;
`endif

  assign rise = rise_q;

endmodule

// File: rtl/sw_event_arbiter.sv
// Switch event arbiter: turns switch rising edges into pending requests and grants
// them round-robin over a valid/ready handshake. SW_DEBOUNCE_EN adds debouncing.
module sw_event_arbiter
  import sw_arb_pkg::*;
#(
  parameter int N               = 4,
  parameter int GAP             = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           sw_in,
  input  logic                   clr_ovr,
  output logic [N-1:0]           pending,
  output logic                   overrun,
  sw_event_arbiter_if.master     evt
);

  localparam int IW = $clog2(N);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [1:0]    ARM_LAST = 2'(ARM_CYCLES - 1);

  state_t        state, state_d;
  logic [1:0]    arm_cnt, arm_cnt_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic [N-1:0]  pending_d;
  logic          overrun_d;
  logic [N-1:0]  rise;
  logic          settled;
  logic          hs;
  logic [N-1:0]  hs_vec;
  pick_t         pick;

  sw_sync_edge #(
    .N               (N),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_in   (sw_in),
    .mask    (state == ST_ARM),
    .rise    (rise),
    .settled (settled)
  );

  assign hs     = (state == ST_OFFER) && evt.evt_ready;
  assign hs_vec = hs ? onehot_q : '0;
  assign pick   = rr_pick(MAX_N'(pending), 3'(ptr), N);

  // A new rise beats a same-cycle handshake clear, and an overrun set beats clr_ovr.
  always_comb begin
    pending_d = (pending & ~hs_vec) | rise;
    overrun_d = overrun;
    if ((rise & pending & ~hs_vec) != '0) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state;
    arm_cnt_d = arm_cnt;
    gap_cnt_d = gap_cnt;
    ptr_d     = ptr;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    case (state)
      ST_ARM: begin
        if (arm_cnt == ARM_LAST) begin
          if (settled) state_d = ST_IDLE;
        end else begin
          arm_cnt_d = arm_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pick.found) begin
          idx_d    = IW'(pick.idx);
          onehot_d = {{(N-1){1'b0}}, 1'b1} << pick.idx;
          state_d  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt.evt_ready) begin
          ptr_d     = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          idx_d     = '0;
          onehot_d  = '0;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ARM;
      arm_cnt  <= '0;
      gap_cnt  <= '0;
      ptr      <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      pending  <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      arm_cnt  <= arm_cnt_d;
      gap_cnt  <= gap_cnt_d;
      ptr      <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      pending  <= pending_d;
      overrun  <= overrun_d;
    end
  end

  // Valid comes straight from the state register so async reset drops it at once.
  assign evt.evt_valid  = (state == ST_OFFER);
  assign evt.evt_idx    = idx_q;
  assign evt.evt_onehot = onehot_q;

endmodule

// File: tb/tb_sw_event_arbiter.sv
// Directed and randomised bench for sw_event_arbiter, checked every cycle
// against a request-level reference model of the switch-to-event rules.
module tb_sw_event_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] sw_in   = '0;
  logic         clr_ovr = 1'b0;
  logic [N-1:0] pending;
  logic         overrun;

  int tests = 0;
  int fails = 0;

  // Reference model: switch history, pending set, grant pointer, offer, cooldown.
  int           edge_n;
  logic [N-1:0] hist [0:4];
  logic [N-1:0] m_pending;
  logic         m_valid;
  int           m_idx;
  int           m_ptr;
  logic         m_ovr;
  int           m_hold;

  sw_event_arbiter_if #(.N(N)) evt ();

  sw_event_arbiter #(
    .N               (N),
    .GAP             (GAP),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_in   (sw_in),
    .clr_ovr (clr_ovr),
    .pending (pending),
    .overrun (overrun),
    .evt     (evt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    edge_n    = 0;
    for (int k = 0; k < 5; k++) hist[k] = '0;
    m_pending = '0;
    m_valid   = 1'b0;
    m_idx     = 0;
    m_ptr     = 0;
    m_ovr     = 1'b0;
    m_hold    = 0;
  endtask

  // Advance the model by one clock edge: a switch rise reaches pending three
  // edges after it is sampled, and no request is taken during the first four edges.
  task automatic modelStep(input logic [N-1:0] sw, input logic rdy, input logic clr);
    logic [N-1:0] rise;
    logic [N-1:0] hsbit;
    logic [N-1:0] oldp;
    edge_n++;
    for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = sw;
    rise  = (edge_n > 4) ? (hist[3] & ~hist[4]) : '0;
    hsbit = '0;
    if (m_valid && rdy) hsbit[m_idx] = 1'b1;
    oldp = m_pending;
    if ((rise & oldp & ~hsbit) != '0) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_pending = (oldp & ~hsbit) | rise;
    if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        m_ptr   = (m_idx + 1) % N;
        m_hold  = GAP;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (edge_n >= 4 && oldp != '0) begin
      for (int k = 0; k < N; k++) begin
        if (!m_valid && oldp[(m_ptr + k) % N]) begin
          m_valid = 1'b1;
          m_idx   = (m_ptr + k) % N;
        end
      end
    end
  endtask

  task automatic compareModel();
    logic [N-1:0] oh;
    oh = '0;
    if (m_valid) oh[m_idx] = 1'b1;
    checkOutput("evt_valid",  32'(evt.evt_valid),  32'(m_valid));
    checkOutput("evt_idx",    32'(evt.evt_idx),    m_valid ? m_idx : 0);
    checkOutput("evt_onehot", 32'(evt.evt_onehot), 32'(oh));
    checkOutput("pending",    32'(pending),        32'(m_pending));
    checkOutput("overrun",    32'(overrun),        32'(m_ovr));
  endtask

  task automatic applyStimulus(input logic [N-1:0] sw, input logic rdy, input logic clr);
    @(negedge clk);
    compareModel();
    sw_in         = sw;
    evt.evt_ready = rdy;
    clr_ovr       = clr;
    modelStep(sw, rdy, clr);
  endtask

  task automatic doReset(input logic [N-1:0] sw_hold);
    rst_n         = 1'b0;
    sw_in         = sw_hold;
    evt.evt_ready = 1'b0;
    clr_ovr       = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (evt.evt_valid !== 1'b1 && n < 20) begin
      applyStimulus('0, 1'b0, 1'b0);
      n++;
    end
    checkOutput(tag, 32'(evt.evt_valid), 32'd1);
  endtask

  initial begin
    int           nvalid;
    int           at;
    int           seen_idx;
    int           first_idx;
    int           order [$];
    logic [N-1:0] rsw;

    // Switch held high through reset must never produce an event.
    doReset(4'b0100);
    repeat (10) applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("arm_no_valid", 32'(evt.evt_valid), 32'd0);
    checkOutput("arm_no_pending", 32'(pending), 32'd0);
    repeat (3) applyStimulus('0, 1'b1, 1'b0);

    // Single rise on bit 1: one-cycle offer exactly four edges later.
    nvalid = 0; at = -1; seen_idx = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i < 2) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      if (evt.evt_valid === 1'b1) begin
        nvalid++;
        at       = i;
        seen_idx = int'(evt.evt_idx);
      end
    end
    checkOutput("single_latency", at, 5);
    checkOutput("single_count", nvalid, 1);
    checkOutput("single_idx", seen_idx, 1);

    // Simultaneous rises on 0, 2, 3 from a fresh pointer.
    doReset('0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus((i == 5 || i == 6) ? 4'b1101 : 4'b0000, 1'b1, 1'b0);
      if (evt.evt_valid === 1'b1) order.push_back(int'(evt.evt_idx));
    end
    checkOutput("rr_count", order.size(), 3);
    checkOutput("rr_first", order[0], 0);
    checkOutput("rr_second", order[1], 2);
    checkOutput("rr_third", order[2], 3);

    // Stalled offer on bit 3, overrun from a repeat rise, then clear.
    repeat (2) applyStimulus(4'b1000, 1'b0, 1'b0);
    waitValid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("stall_valid", 32'(evt.evt_valid), 32'd1);
      checkOutput("stall_idx", 32'(evt.evt_idx), 32'd3);
      checkOutput("stall_onehot", 32'(evt.evt_onehot), 32'h8);
    end
    repeat (2) applyStimulus(4'b1000, 1'b0, 1'b0);
    repeat (3) applyStimulus('0, 1'b0, 1'b0);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    applyStimulus('0, 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("overrun_clr", 32'(overrun), 32'd0);

    // Rise on bit 2 lands on the same edge as its own handshake.
    repeat (6) applyStimulus('0, 1'b1, 1'b0);
    repeat (2) applyStimulus(4'b0100, 1'b0, 1'b0);
    waitValid("same_wait");
    checkOutput("same_idx", 32'(evt.evt_idx), 32'd2);
    repeat (2) applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, 1'b0);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("same_pending", 32'(pending), 32'h4);
    checkOutput("same_no_overrun", 32'(overrun), 32'd0);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus('0, 1'b1, 1'b0);
      if (evt.evt_valid === 1'b1 && evt.evt_idx === 2'd2) nvalid++;
    end
    checkOutput("same_regrant", nvalid, 1);

    // Asynchronous reset in the middle of an offer.
    repeat (2) applyStimulus(4'b1010, 1'b0, 1'b0);
    waitValid("rst_wait");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(evt.evt_valid), 32'd0);
    checkOutput("rst_onehot", 32'(evt.evt_onehot), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    doReset('0);
    first_idx = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i == 5 || i == 6) ? 4'b1010 : 4'b0000, 1'b1, 1'b0);
      if (evt.evt_valid === 1'b1 && first_idx < 0) first_idx = int'(evt.evt_idx);
    end
    checkOutput("rst_ptr_zero", first_idx, 1);

    // Randomised traffic against the model.
    rsw = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) rsw[b] = ~rsw[b];
      end
      applyStimulus(rsw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    applyStimulus('0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
